// File: rtl/timer_intr_ctrl_if.sv
// timer_intr_ctrl_if: register bus between the CPU data path and the timer/interrupt block.
interface timer_intr_ctrl_if;
   logic        sel;
   logic        wr;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master(output sel, wr, addr, wdata, input rdata);
   modport slave(input sel, wr, addr, wdata, output rdata);
endinterface

// File: rtl/timer_intr_ctrl.sv
// timer_intr_ctrl: 64-bit machine timer with prescaler plus synchronized, edge-latched external IRQ.
module timer_intr_ctrl #(
   parameter int          PRESCALE_W   = 8,
   parameter int          SYNC_STAGES  = 2,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   timer_intr_ctrl_if.slave  bus,
   input  logic              ext_irq,
   input  logic              intr_ack,
   output logic [3:0]        interrupt
);
   logic [63:0]            mtime, mtimecmp;
   logic [PRESCALE_W-1:0]  prescale, pcnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   timer_en, ext_en, timer_pend, ext_pend, sync_d;
   logic                   we, tick, ext_edge, ext_clr;

   assign we        = bus.sel & bus.wr;
   assign tick      = timer_en & (pcnt == prescale);
   assign ext_edge  = sync[SYNC_STAGES-1] & ~sync_d;
   assign ext_clr   = (intr_ack & (interrupt == 4'd2)) | (we & (bus.addr == 3'd5) & bus.wdata[1]);
   assign interrupt = (ext_pend & ext_en) ? 4'd2 : timer_pend ? 4'd1 : 4'd0;

   always_comb begin
      bus.rdata = '0;
      if (bus.sel & ~bus.wr)
         case (bus.addr)
            3'd0:    bus.rdata = mtime[31:0];
            3'd1:    bus.rdata = mtime[63:32];
            3'd2:    bus.rdata = mtimecmp[31:0];
            3'd3:    bus.rdata = mtimecmp[63:32];
            3'd4:    bus.rdata = 32'({prescale, 6'b0, ext_en, timer_en});
            3'd5:    bus.rdata = {30'b0, ext_pend, timer_pend};
            default: bus.rdata = '0;
         endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime      <= '0;
         mtimecmp   <= MTIMECMP_RST;
         timer_en   <= 1'b0;
         ext_en     <= 1'b0;
         prescale   <= '0;
         pcnt       <= '0;
         sync       <= '0;
         sync_d     <= 1'b0;
         timer_pend <= 1'b0;
         ext_pend   <= 1'b0;
      end else begin
         pcnt <= (!timer_en || tick) ? '0 : pcnt + 1'b1;
         // a bus write to either half takes priority over the tick increment
         if (we && bus.addr == 3'd0) mtime[31:0] <= bus.wdata;
         else if (we && bus.addr == 3'd1) mtime[63:32] <= bus.wdata;
         else if (tick) mtime <= mtime + 64'd1;
         if (we && bus.addr == 3'd2) mtimecmp[31:0] <= bus.wdata;
         if (we && bus.addr == 3'd3) mtimecmp[63:32] <= bus.wdata;
         if (we && bus.addr == 3'd4) begin
            timer_en <= bus.wdata[0];
            ext_en   <= bus.wdata[1];
            prescale <= bus.wdata[8 +: PRESCALE_W];
         end
         timer_pend <= timer_en & (mtime >= mtimecmp);
         sync       <= {sync[SYNC_STAGES-2:0], ext_irq};
         sync_d     <= sync[SYNC_STAGES-1];
         ext_pend   <= (ext_edge & ext_en) | (ext_pend & ~ext_clr);
      end
   end
endmodule
